pyramid_downsampler: RTL and testbench
======================================

PYRAMID_DOWNSAMPLER -- requirements
Module: pyramid_downsampler

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- COL, 800, active pixels per line.
- ROW, 600, active lines per frame.
- DW, 8, pixel width in bits.
- K, 1, log2 of the decimation factor F = 2^K; legal values 1..3.
REQ-002 Parameter constraints SHALL be COL and ROW integer multiples of F; instantiation SHALL fail elaboration otherwise.
REQ-003 Ports SHALL be, as name, direction, width, meaning:
- VGA_Clk, in, 1, sole clock.
- Reset, in, 1, synchronous active-high reset.
- Clk_en, in, 1, input-side enable.
- Din, in, DW, input pixel.
- Din_valid, in, 1, input pixel qualifier; no backpressure.
- Dout, out, DW, output pixel.
- Dout_valid, out, 1, output pixel available.
- Dout_ready, in, 1, consumer accepts output.
- Frame_done, out, 1, one-cycle pulse at end of input frame.
- Overflow, out, 1, sticky: an output sample was dropped.
REQ-004 Clock and reset SHALL be as follows: reset Reset, synchronous, active-high; clock VGA_Clk.

Function
REQ-005 A pixel SHALL be accepted on a VGA_Clk edge where Din_valid=1 and Clk_en=1; all other cycles SHALL leave the counters and accumulators unchanged.
REQ-006 The column counter SHALL run 0..COL-1 per accepted pixel and wrap to 0; the row counter SHALL increment on that wrap, run 0..ROW-1, and wrap to 0 after the last pixel of the frame.
REQ-007 An emit event SHALL occur on an accepted pixel with col mod F = F-1 and row mod F = F-1; this yields (COL/F)x(ROW/F) outputs per frame in raster order.
REQ-008 In decimate mode, the emitted value SHALL be the accepted Din at the emit position.
REQ-009 Dout/Dout_valid SHALL be registered, with a latency of exactly 1 VGA_Clk cycle from the emitting accepted pixel to Dout_valid=1.
REQ-010 Output handshake: a transfer SHALL occur when Dout_valid=1 and Dout_ready=1; Dout_valid SHALL clear the next cycle unless a new emit occurs in the same cycle, in which case the new sample SHALL load and Dout_valid SHALL remain 1.
REQ-011 While Dout_valid=1 and Dout_ready=0, Dout SHALL hold stable.
REQ-012 An emit arriving while the output is stalled SHALL be dropped, the held sample SHALL be kept, and Overflow SHALL set to 1 and stay set until Reset.
REQ-013 Frame_done SHALL pulse high for 1 cycle, on the cycle after acceptance of pixel (col=COL-1, row=ROW-1).
REQ-014 Clk_en=0 SHALL NOT block the output handshake; Dout_ready transfers SHALL proceed.

Reset
REQ-015 While Reset=1, counters, accumulators and line-accumulator contents SHALL clear to 0, with Dout=0, Dout_valid=0, Frame_done=0 and Overflow=0.
REQ-016 Reset SHALL take priority over Din_valid, Clk_en and Dout_ready in the same cycle.
REQ-017 Reset asserted mid-frame SHALL discard the partial frame, and the next accepted pixel after release SHALL be treated as (col=0, row=0).

Configuration
REQ-018 Macro DS_BOX_AVERAGE_EN SHALL select the output mode:
- Defined: box-average mode, with Dout = floor(sum of the FxF block / F^2).
  - Partial sums SHALL be width DW+2K, with no overflow.
  - Per-column-group partial sums SHALL be held in a COL/F-entry line accumulator.
  - The accumulator entry SHALL be cleared when its block emits.
- Undefined: decimate mode per REQ-008, with no line accumulator or adder logic synthesised.
REQ-019 Latency, handshake, Overflow and Frame_done behaviour SHALL be identical in both modes.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Scenario 1: COL=8, ROW=4, K=1, decimate, Din=row*8+col, Dout_ready=1 -> outputs 9,11,13,15,25,27,29,31; Frame_done pulses once, 1 cycle after pixel 31.
- Scenario 2: same stimulus, DS_BOX_AVERAGE_EN defined -> outputs 4,6,8,10,20,22,24,26 (floor of block averages).
- Scenario 3: K=1, average mode, all Din=255 -> every Dout=255 (no accumulator overflow); DW=8, K=3, all Din=255 -> Dout=255.
- Scenario 4: Dout_ready=0 held across two emits -> the first sample is held, the second is dropped, Overflow=1 and stays set; after Dout_ready=1 the first sample transfers.
- Scenario 5: Reset pulsed at col=5, row=2 of an 8x4 frame -> all outputs 0 the next cycle; the following frame's outputs match Scenario 1 exactly.
- Scenario 6: Din_valid toggled 1/0 and Clk_en toggled low every third cycle -> the output sequence is identical to Scenario 1; only timing is stretched.

Source files
------------

// File: rtl/pyramid_downsampler.sv
// pyramid_downsampler: one pyramid level, FxF (F=2**K) raster downsampler.
// Default output is decimation; define DS_BOX_AVERAGE_EN for box averaging.
module pyramid_downsampler #(
  parameter int COL = 800,
  parameter int ROW = 600,
  parameter int DW  = 8,
  parameter int K   = 1
) (
  input  logic          VGA_Clk,
  input  logic          Reset,
  input  logic          Clk_en,
  input  logic [DW-1:0] Din,
  input  logic          Din_valid,
  output logic [DW-1:0] Dout,
  output logic          Dout_valid,
  input  logic          Dout_ready,
  output logic          Frame_done,
  output logic          Overflow
);

  localparam int F  = 1 << K;
  localparam int NG = COL / F;
  localparam int CW = (COL > 1) ? $clog2(COL) : 1;
  localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);

  if ((COL % F) != 0 || (ROW % F) != 0 || K < 1 || K > 3)
  begin : g_bad_cfg
    $error("pyramid_downsampler: COL/ROW not multiples of 2**K or K outside 1..3");
  end

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          emit;
  logic [DW-1:0] emit_val;

  assign accept   = Din_valid & Clk_en;
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign emit     = accept
                  & (&col[K-1:0])
                  & (&row[K-1:0]);

  always_ff @(posedge VGA_Clk) begin
    if (Reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

`ifdef DS_BOX_AVERAGE_EN
  localparam int AW = DW + 2 * K;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;

  logic [AW-1:0] line_acc [NG];
  logic [GW-1:0] grp;
  logic [AW-1:0] sum;

  assign grp      = GW'(col >> K);
  assign sum      = line_acc[grp] + AW'(Din);
  // A full block sum is < F*F*2**DW, so the top DW bits are the floor mean.
  assign emit_val = sum[AW-1:2*K];

  always_ff @(posedge VGA_Clk) begin
    if (Reset) begin
      for (int i = 0; i < NG; i++) begin
        line_acc[i] <= '0;
      end
    end else if (accept) begin
      line_acc[grp] <= emit ? '0 : sum;
    end
  end
`else
  assign emit_val = Din;
`endif

  always_ff @(posedge VGA_Clk) begin
    if (Reset) begin
      Dout       <= '0;
      Dout_valid <= 1'b0;
      Overflow   <= 1'b0;
      Frame_done <= 1'b0;
    end else begin
      Frame_done <= accept & col_last & row_last;
      if (emit) begin
        // A stalled output keeps its sample; the newcomer is lost.
        if (Dout_valid && !Dout_ready) begin
          Overflow <= 1'b1;
        end else begin
          Dout       <= emit_val;
          Dout_valid <= 1'b1;
        end
      end else if (Dout_valid && Dout_ready) begin
        Dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pyramid_downsampler.sv
// Randomised and directed bench for pyramid_downsampler (8x4 K=1, 16x8 K=3).
// Reference model works on whole-frame pixel arrays and block arithmetic.
module tb_pyramid_downsampler;

  localparam int C = 8;
  localparam int R = 4;
  localparam int F = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       dv  = 1'b0;
  logic       dv2 = 1'b0;
  logic       rdy = 1'b1;
  logic [7:0] din = '0;
  logic [7:0] din2 = '0;
  logic [7:0] dout, dout2;
  logic       vo, fd, ovf;
  logic       vo2, fd2, ovf2;

  always #5 clk = ~clk;

  pyramid_downsampler #(.COL(C), .ROW(R), .DW(8), .K(1)) u_dut (
    .VGA_Clk(clk), .Reset(rst), .Clk_en(en),
    .Din(din), .Din_valid(dv),
    .Dout(dout), .Dout_valid(vo), .Dout_ready(rdy),
    .Frame_done(fd), .Overflow(ovf)
  );

  pyramid_downsampler #(.COL(16), .ROW(8), .DW(8), .K(3)) u_k3 (
    .VGA_Clk(clk), .Reset(rst), .Clk_en(en),
    .Din(din2), .Din_valid(dv2),
    .Dout(dout2), .Dout_valid(vo2), .Dout_ready(rdy),
    .Frame_done(fd2), .Overflow(ovf2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int fd_cnt  = 0;

  int         mc, mr;
  int         pix [R][C];
  logic       m_v, m_f, m_o;
  logic [7:0] m_d;

  logic [7:0] got  [$];
  logic [7:0] got2 [$];
  int         exp1 [8];
  int         q    [8][16];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int blk_val(input int c, input int r);
    int s;
    s = 0;
`ifdef DS_BOX_AVERAGE_EN
    for (int y = r - F + 1; y <= r; y++)
      for (int x = c - F + 1; x <= c; x++)
        s += pix[y][x];
    return s / (F * F);
`else
    s = pix[r][c];
    return s;
`endif
  endfunction

  task automatic model();
    bit acc, emit;
    int v;
    if (rst) begin
      mc = 0; mr = 0;
      m_v = 0; m_d = '0; m_f = 0; m_o = 0;
    end else begin
      acc  = dv && en;
      emit = 0;
      v    = 0;
      m_f  = acc && mc == C - 1 && mr == R - 1;
      if (acc) begin
        pix[mr][mc] = int'(din);
        emit = (mc % F == F - 1) && (mr % F == F - 1);
        if (emit) v = blk_val(mc, mr);
      end
      if (emit) begin
        if (m_v && !rdy) m_o = 1;
        else begin
          m_d = v[7:0];
          m_v = 1;
        end
      end else if (m_v && rdy) begin
        m_v = 0;
      end
      if (acc) begin
        if (mc == C - 1) begin
          mc = 0;
          mr = (mr == R - 1) ? 0 : mr + 1;
        end else begin
          mc++;
        end
      end
    end
  endtask

  task automatic step();
    if (vo === 1'b1 && rdy) got.push_back(dout);
    if (vo2 === 1'b1 && rdy) got2.push_back(dout2);
    @(posedge clk);
    model();
    #1;
    check("valid", vo, m_v);
    if (m_v) check("dout", dout, m_d);
    check("fdone", fd, m_f);
    check("ovf", ovf, m_o);
    if (fd === 1'b1) fd_cnt++;
  endtask

  task automatic pix_in(input int v);
    din = v[7:0];
    dv  = 1'b1;
    en  = 1'b1;
    step();
  endtask

  task automatic idle(input int n);
    dv = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dv  = 1'b0;
    step();
    rst = 1'b0;
    got.delete();
    fd_cnt = 0;
  endtask

  task automatic check_tbl(input string tag);
    check({tag, "_n"}, got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      check(tag, got[i], exp1[i]);
  endtask

  task automatic k3_frame(input bit all_max);
    int s0, s1;
    got2.delete();
    s0 = 0; s1 = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++) begin
        q[r][c] = all_max ? 255 : int'($urandom_range(0, 255));
        if (c < 8) s0 += q[r][c];
        else       s1 += q[r][c];
      end
    dv = 1'b0;
    en = 1'b1;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++) begin
        din2 = q[r][c][7:0];
        dv2  = 1'b1;
        step();
      end
    dv2 = 1'b0;
    idle(3);
    check("k3_n", got2.size(), 2);
`ifdef DS_BOX_AVERAGE_EN
    if (got2.size() == 2) begin
      check("k3_b0", got2[0], s0 / 64);
      check("k3_b1", got2[1], s1 / 64);
    end
`else
    if (got2.size() == 2) begin
      check("k3_b0", got2[0], q[7][7]);
      check("k3_b1", got2[1], q[7][15]);
    end
`endif
  endtask

  initial begin
    int p, t, cyc;
`ifdef DS_BOX_AVERAGE_EN
    exp1 = '{4, 6, 8, 10, 20, 22, 24, 26};
`else
    exp1 = '{9, 11, 13, 15, 25, 27, 29, 31};
`endif

    rst = 1'b1;
    repeat (2) step();
    check("rst_dout", dout, 0);
    check("rst_vo", vo, 0);
    check("rst_vo2", vo2, 0);
    rst = 1'b0;
    got.delete();

    // Plain raster frame, consumer always ready.
    do_reset();
    rdy = 1'b1;
    for (int i = 0; i < 32; i++) pix_in(i);
    idle(3);
    check_tbl("s1");
    check("s1_fd", fd_cnt, 1);

    // Gappy input: Din_valid alternates, Clk_en low every third cycle.
    do_reset();
    p = 0; t = 0;
    while (p < 32 && t < 200) begin
      din = p[7:0];
      dv  = (t % 2 == 0);
      en  = (t % 3 != 2);
      if (dv && en) p++;
      step();
      t++;
    end
    en = 1'b1;
    idle(3);
    check("s6_cnt", p, 32);
    check_tbl("s6");
    check("s6_fd", fd_cnt, 1);

    // Reset in the middle of a frame.
    do_reset();
    for (int i = 0; i < 21; i++) pix_in(i);
    rst = 1'b1;
    pix_in(21);
    check("s5_dout", dout, 0);
    check("s5_vo", vo, 0);
    check("s5_ovf", ovf, 0);
    rst = 1'b0;
    got.delete();
    fd_cnt = 0;
    for (int i = 0; i < 32; i++) pix_in(i);
    idle(3);
    check_tbl("s5");

    // Stalled output across two emits.
    do_reset();
    rdy = 1'b0;
    for (int i = 0; i < 12; i++) pix_in(i);
    check("s4_ovf", ovf, 1);
    check("s4_vo", vo, 1);
    check("s4_hold", dout, exp1[0]);
    idle(2);
    check("s4_hold2", dout, exp1[0]);
    rdy = 1'b1;
    idle(1);
    check("s4_n", got.size(), 1);
    if (got.size() >= 1) check("s4_first", got[0], exp1[0]);
    for (int i = 12; i < 32; i++) pix_in(i);
    idle(2);
    check("s4_sticky", ovf, 1);

    // Saturated input must not overflow the block sums.
    do_reset();
    for (int i = 0; i < 32; i++) pix_in(255);
    idle(3);
    check("s3_n", got.size(), 8);
    for (int i = 0; i < got.size(); i++) check("s3_max", got[i], 255);

    // Randomised traffic with random backpressure, checked every cycle.
    do_reset();
    p = 0; cyc = 0;
    while (p < 96 && cyc < 2000) begin
      din = 8'($urandom_range(0, 255));
      dv  = ($urandom_range(0, 3) != 0);
      en  = ($urandom_range(0, 4) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      if (dv && en) p++;
      step();
      cyc++;
    end
    rdy = 1'b1;
    en  = 1'b1;
    idle(3);
    check("rnd_cnt", p, 96);

    // K=3 instance: saturated frame, then a random one.
    k3_frame(1'b1);
    k3_frame(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
